// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: N-times oversampling with a 3-sample majority vote,
// optional odd/even parity, 1 or 2 stop bits, separate parity/framing/break flags.
module uart_rx_cfg #(
  parameter int CLOCK_RATE = 12000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxEn,
  input  logic                 rxIn,
  output logic                 rxBusy,
  output logic                 rxDone,
  output logic [DATA_BITS-1:0] rxOut,
  output logic                 rxErr,
  output logic                 parityErr,
  output logic                 frameErr,
  output logic                 rxBreak
);
  localparam int DIV_RAW = CLOCK_RATE / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int BW      = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t               state, state_d;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic                 tick;
  logic [SW-1:0]        samp_cnt, idx_next, hi_cnt;
  logic                 s0_q, s1_q, maj, vote;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bit_q, par_err_q, frm_err_q, brk_q;
  logic                 start_go, frame_end, last_data, last_stop, brk_now, par_x;

  // Idle-high line: the synchroniser resets to 1 so reset release never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rxIn};
  end
  assign rx_s = sync_q[1];

  assign tick     = (tick_cnt == TW'(DIV - 1));
  assign idx_next = (samp_cnt == SW'(OVERSAMPLE - 1)) ? '0 : samp_cnt + 1'b1;
  assign vote     = tick && (idx_next == SW'(OVERSAMPLE / 2 + 1));
  assign maj      = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign last_data = (bit_cnt == BW'(DATA_BITS - 1));
  assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));
  assign par_x     = (^shift_q) ^ maj;
  assign brk_now   = (shift_q == '0) && !par_bit_q && !maj;
  assign start_go  = (state == S_IDLE) && (state_d == S_START);
  assign rxBusy    = (state != S_IDLE);

  // NOTE: every output of a combinational block gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d   = state;
    frame_end = 1'b0;
    if (!rxEn) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (!rx_s) state_d = S_START;
        S_START:     if (vote) state_d = maj ? S_IDLE : S_DATA;
        S_DATA:      if (vote && last_data) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
        S_PARITY:    if (vote) state_d = S_STOP;
        S_STOP: begin
          if (vote && last_stop) begin
            frame_end = 1'b1;
            state_d   = maj ? S_IDLE : S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: if (tick && rx_s && hi_cnt == SW'(OVERSAMPLE - 1)) state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Tick phase restarts at the start edge so the vote points sit mid-bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      samp_cnt <= '0;
      s0_q     <= 1'b1;
      s1_q     <= 1'b1;
    end else begin
      tick_cnt <= (start_go || tick) ? '0 : tick_cnt + 1'b1;
      if (start_go)  samp_cnt <= '0;
      else if (tick) samp_cnt <= idx_next;
      if (tick && idx_next == SW'(OVERSAMPLE / 2 - 1)) s0_q <= rx_s;
      if (tick && idx_next == SW'(OVERSAMPLE / 2))     s1_q <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      brk_q     <= 1'b0;
      hi_cnt    <= '0;
      rxDone    <= 1'b0;
      rxOut     <= '0;
      rxErr     <= 1'b0;
      parityErr <= 1'b0;
      frameErr  <= 1'b0;
      rxBreak   <= 1'b0;
    end else begin
      rxDone <= frame_end;
      if (start_go) begin
        bit_cnt   <= '0;
        par_bit_q <= 1'b0;
        par_err_q <= 1'b0;
        frm_err_q <= 1'b0;
        brk_q     <= 1'b0;
      end else if (vote) begin
        case (state)
          S_DATA: begin
            shift_q <= {maj, shift_q[DATA_BITS-1:1]};
            bit_cnt <= last_data ? '0 : bit_cnt + 1'b1;
          end
          S_PARITY: begin
            par_bit_q <= maj;
            par_err_q <= (PARITY == 1) ? !par_x : par_x;
          end
          S_STOP: begin
            bit_cnt <= bit_cnt + 1'b1;
            if (!maj) frm_err_q <= 1'b1;
            if (bit_cnt == '0) brk_q <= brk_now;
          end
          default: ;
        endcase
      end
      // WAIT_IDLE needs a full bit time of consecutive high ticks.
      if (state != S_WAIT_IDLE) hi_cnt <= '0;
      else if (tick)            hi_cnt <= rx_s ? hi_cnt + 1'b1 : '0;
      if (frame_end) begin
        rxOut     <= shift_q;
        parityErr <= par_err_q;
        frameErr  <= frm_err_q | !maj;
        rxErr     <= par_err_q | frm_err_q | !maj;
        rxBreak   <= (STOP_BITS == 1) ? brk_now : brk_q;
      end
    end
  end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the fixed 8-bit UART receive path. It supports configurable data width, optional odd/even parity, 1 or 2 stop bits, and N× oversampling with majority-vote bit decisions. It reports parity errors, framing errors and line breaks separately, and recovers cleanly after a bad frame. It sits between the pad-side serial input and the byte consumer, as a drop-in for the receive half of Uart8 when a non-8N1 link is needed.

Parameters:
- CLOCK_RATE, 12000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line bit rate in bits per second.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and ≥ 8.
- DATA_BITS, 8: payload width. Legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rxEn  in  1  receiver enable.
- rxIn  in  1  raw serial line, idle high. Asynchronous to clk.
- rxBusy  out  1  high while a frame is in progress or the block is waiting for the line to go idle.
- rxDone  out  1  one-cycle pulse when a frame completes.
- rxOut  out  DATA_BITS  received payload, LSB first on the wire.
- rxErr  out  1  parityErr OR frameErr.
- parityErr  out  1  parity mismatch on the last frame.
- frameErr  out  1  a stop bit was sampled low on the last frame.
- rxBreak  out  1  the last frame was an all-zero break.

Behaviour:
- Reset (async, active-high) forces all outputs to 0, the FSM to IDLE, and the synchroniser flops to 1. Release is synchronous to clk.
- Input synchroniser: rxIn passes through a 2-flop synchroniser. All logic uses the synchronised value, rxS.
- Tick generator:
  - DIV = CLOCK_RATE / (BAUD_RATE × OVERSAMPLE), integer floor, minimum 1.
  - One-cycle tick every DIV clocks.
  - The tick counter is cleared on entry to START.
- Majority vote: each bit value is the majority of the samples at ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1 within that bit.
- FSM states:
  - IDLE: while rxEn=1 and rxS=0, go to START; rxBusy goes high the same cycle.
  - START: at the vote point, majority 1 means a false start: return to IDLE, rxBusy goes low, no rxDone. Majority 0 goes to DATA.
  - DATA: shift in DATA_BITS bits, LSB first. Then go to PARITY if PARITY≠0, otherwise to STOP.
  - PARITY: sample the parity bit and check it.
    - odd: XOR of the data bits and the parity bit must be 1.
    - even: that XOR must be 0.
  - STOP: sample STOP_BITS stop bits. Any low stop bit sets frameErr for this frame.
    - At the vote point of the last stop bit, complete the frame.
    - Then go to IDLE if the last stop bit was high, otherwise to WAIT_IDLE.
  - WAIT_IDLE: rxBusy stays high. Return to IDLE after rxS has been high for one full bit time (OVERSAMPLE consecutive ticks).
- Frame completion, in a single cycle:
  - rxDone pulses.
  - rxOut, parityErr, frameErr, rxBreak and rxErr all update together.
  - These values hold until the next rxDone.
- Break: rxBreak=1 when all data bits, the parity bit (if present) and the first stop bit are 0. frameErr=1 in that case; rxOut=0.
- Latency: rxDone follows the start edge on rxIn by (1 + DATA_BITS + P + STOP_BITS − 0.5) bit times, plus the 2–3 synchroniser and edge cycles. P is 1 when PARITY≠0, otherwise 0.
- rxEn=0 in any state: abort to IDLE on the next clock.
  - rxBusy goes to 0; no rxDone.
  - rxOut and the error flags hold their values.
- Back-to-back frames: a start edge in the cycle immediately after STOP→IDLE is accepted. No dead time beyond the half stop bit.
- An rxIn edge coinciding with a tick is sampled post-synchroniser only; no special case.

Test Plan:
1. Default 8N1 (DIV=78); send 0x45 at 9600 baud → exactly one rxDone pulse; rxOut=0x45; rxErr=parityErr=frameErr=rxBreak=0; rxBusy high for ~9.5 bit times.
2. PARITY=2, DATA_BITS=8; send 0x45 with parity bit 0 (correct value is 1) → rxDone; rxOut=0x45; parityErr=1; rxErr=1; frameErr=0. Resend with parity 1 → all flags 0.
3. Send 0xA5 with stop bit held low for 2 bit times, then high → rxDone; frameErr=1; rxOut=0xA5; rxBusy stays high until one bit time after the line returns high, then 0.
4. Low glitch of 3 clock cycles on rxIn while idle → no rxDone; rxBusy returns to 0 within 0.6 bit time; flags from the previous frame unchanged.
5. Line held low for 12 bit times, then high → rxBreak=1, frameErr=1, rxOut=0. A following valid 0x3C frame → rxOut=0x3C, rxBreak=0.
6. Assert rst mid-frame → all outputs 0 immediately (asynchronous, not waiting for a clock edge). Separately, drop rxEn at data bit 4 → no rxDone, rxBusy=0 next cycle. DATA_BITS=5, STOP_BITS=2; send 0x1F → rxOut=0x1F.
